// File: rtl/e603_exu_nice_disp.sv
// e603_exu_nice_disp: NICE co-processor dispatch. Issues decoded instructions
// straight through to the NICE request port, remembers {rdidx, rd_en} of each
// outstanding request in an in-order FIFO, and steers in-order responses to
// the integer writeback port.
// Optional feature macro: E603_NICE_RSP_SKID_EN -- adds a one-entry skid
// register between the NICE response and writeback (breaks the
// wbck_ready -> nice_rsp_ready combinational path, +1 cycle latency).
module e603_exu_nice_disp #(
  parameter int OSTD_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [4:0]  i_rdidx,
  input  logic        i_rd_en,
  output logic        nice_req_valid,
  input  logic        nice_req_ready,
  output logic [31:0] nice_req_instr,
  output logic [31:0] nice_req_rs1,
  output logic [31:0] nice_req_rs2,
  input  logic        nice_rsp_valid,
  output logic        nice_rsp_ready,
  input  logic [31:0] nice_rsp_rdat,
  input  logic        nice_rsp_err,
  output logic        wbck_valid,
  input  logic        wbck_ready,
  output logic [31:0] wbck_wdat,
  output logic [4:0]  wbck_rdidx,
  output logic        wbck_err,
  output logic        nice_busy
);

  localparam int              CW      = $clog2(OSTD_DEPTH);
  localparam logic [CW:0]     L_DEPTH = (CW+1)'(OSTD_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  logic [CW:0]   r_cnt;
  logic [CW-1:0] r_wptr, r_rptr;
  logic [4:0]    r_rdidx [OSTD_DEPTH];
  logic          r_rden  [OSTD_DEPTH];
  state_t        r_state;

  logic          w_full, w_empty, w_push, w_pop;
  logic [4:0]    w_hd_rdidx;
  logic          w_hd_rden, w_report;

  assign w_full     = (r_cnt == L_DEPTH);
  assign w_empty    = (r_cnt == '0);
  assign w_hd_rdidx = r_rdidx[r_rptr];
  assign w_hd_rden  = r_rden[r_rptr];
  // A response reaches writeback if it targets rd or carries an error.
  assign w_report   = w_hd_rden | nice_rsp_err;

  // Issue side is a pure pass-through, gated only by FIFO space (no bypass).
  assign nice_req_valid = i_valid & ~w_full;
  assign i_ready        = nice_req_ready & ~w_full;
  assign nice_req_instr = i_instr;
  assign nice_req_rs1   = i_rs1;
  assign nice_req_rs2   = i_rs2;
  assign w_push         = nice_req_valid & nice_req_ready;
  assign w_pop          = nice_rsp_valid & nice_rsp_ready;
  assign nice_busy      = (r_state == S_WAIT);

`ifdef E603_NICE_RSP_SKID_EN
  logic        r_sk_vld;
  logic [31:0] r_sk_wdat;
  logic [4:0]  r_sk_rdidx;
  logic        r_sk_err;

  assign nice_rsp_ready = ~w_empty & ~r_sk_vld;
  assign wbck_valid     = r_sk_vld;
  assign wbck_wdat      = r_sk_wdat;
  assign wbck_rdidx     = r_sk_rdidx;
  assign wbck_err       = r_sk_err;

  // Skid register: capture reportable responses, release on wbck accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sk_vld   <= 1'b0;
      r_sk_wdat  <= '0;
      r_sk_rdidx <= '0;
      r_sk_err   <= 1'b0;
    end else if (w_pop && w_report) begin
      r_sk_vld   <= 1'b1;
      r_sk_wdat  <= nice_rsp_rdat;
      r_sk_rdidx <= w_hd_rden ? w_hd_rdidx : 5'd0;
      r_sk_err   <= nice_rsp_err;
    end else if (wbck_ready) begin
      r_sk_vld   <= 1'b0;
    end
  end
`else
  // Combinational steering; no-rd, no-error responses are silently consumed.
  always_comb begin
    nice_rsp_ready = 1'b0;
    wbck_valid     = 1'b0;
    wbck_wdat      = nice_rsp_rdat;
    wbck_rdidx     = w_hd_rden ? w_hd_rdidx : 5'd0;
    wbck_err       = nice_rsp_err;
    if (!w_empty) begin
      nice_rsp_ready = w_report ? wbck_ready : 1'b1;
      wbck_valid     = nice_rsp_valid & w_report;
    end
  end
`endif

  // FIFO payload storage, written on issue handshake (no reset needed).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rdidx[r_wptr] <= i_rdidx;
      r_rden[r_wptr]  <= i_rd_en;
    end
  end

  // Occupancy, pointers (wrap modulo depth) and busy FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_state <= S_IDLE;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;
      case (r_state)
        S_IDLE: if (w_push) r_state <= S_WAIT;
        S_WAIT: if (w_pop && !w_push && r_cnt == (CW+1)'(1)) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
